// File: rtl/demux_pkg.sv
// Shared types and defaults for the stream demultiplexer.
package demux_pkg;

  // Single-entry output buffer occupancy.
  typedef enum logic {
    EMPTY,
    FULL
  } buf_state_t;

  localparam int unsigned DEMUX_CNT_W = 8;

endpackage

// File: rtl/demux_stream_if.sv
// Handshake bundle between the producer, the demux and its consumers.
interface demux_stream_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) ();

  logic [WIDTH-1:0]          i;
  logic [SEL_W-1:0]          s;
  logic                      i_valid;
  logic                      i_ready;
  logic [CHANNELS*WIDTH-1:0] y;
  logic [CHANNELS-1:0]       y_valid;
  logic [CHANNELS-1:0]       y_ready;

  // Producer plus consumers as seen from outside the demux.
  modport master (
    output i, s, i_valid, y_ready,
    input  i_ready, y, y_valid
  );

  // The demux itself.
  modport slave (
    input  i, s, i_valid, y_ready,
    output i_ready, y, y_valid
  );

endinterface

// File: rtl/demux_dec.sv
// Select decoder: one-hot channel vector plus an in-range flag.
module demux_dec #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [SEL_W-1:0]    sel,
  output logic [CHANNELS-1:0] onehot,
  output logic                in_range
);

  // Extra bit so CHANNELS itself is representable when it is a power of two.
  localparam logic [SEL_W:0] NumCh = (SEL_W + 1)'(CHANNELS);

  // Out-of-range selects decode to all zeros.
  always_comb begin
    onehot = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      onehot[k] = ({1'b0, sel} == (SEL_W + 1)'(k));
    end
  end

  assign in_range = ({1'b0, sel} < NumCh);

endmodule

// File: rtl/demux_stream.sv
// Registered 1:CHANNELS demux with valid/ready on input and every output.
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS),
  parameter int unsigned CNT_W    = DEMUX_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  demux_stream_if.slave     bus,
  output logic [CNT_W-1:0]  drop_cnt
);

  buf_state_t          state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [SEL_W-1:0]    dest_q, dest_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic [CHANNELS-1:0] sel_oh, dest_oh, y_valid;
  logic                sel_ok, dest_ok;
  logic                in_fire, out_fire, load_ok;

  demux_dec #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_dec_sel (
    .sel      (bus.s),
    .onehot   (sel_oh),
    .in_range (sel_ok)
  );

  demux_dec #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_dec_dest (
    .sel      (dest_q),
    .onehot   (dest_oh),
    .in_range (dest_ok)
  );

  // Handshake terms; i_ready deliberately depends on y_ready but never on i_valid.
  assign bus.i_ready = (state_q == EMPTY) || |(dest_oh & bus.y_ready);
  assign in_fire     = bus.i_valid && bus.i_ready;
  assign out_fire    = |(y_valid & bus.y_ready);
  // Both decoder flags agree for any select; requiring both keeps the load
  // decision tied to the same one-hot that would later drive the outputs.
  assign load_ok     = sel_ok && (|sel_oh);

  // Next-state: load, drain, or drop the incoming word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    drop_d  = drop_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire && load_ok) begin
          state_d = FULL;
          data_d  = bus.i;
          dest_d  = bus.s;
        end
      end
      FULL: begin
        if (in_fire && load_ok) begin
          data_d = bus.i;
          dest_d = bus.s;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
    endcase
    if (in_fire && !load_ok && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // State, buffer and drop counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      dest_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      drop_q  <= drop_d;
    end
  end

  assign y_valid     = ((state_q == FULL) && dest_ok) ? dest_oh : '0;
  assign bus.y_valid = y_valid;
  assign drop_cnt    = drop_q;

  // Only the selected slice carries data; all others are forced to zero.
  always_comb begin
    bus.y = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      bus.y[k*WIDTH +: WIDTH] = y_valid[k] ? data_q : '0;
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench: behavioural buffer model plus directed literal checks.
module tb_demux_stream;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] drop_cnt;

  demux_stream_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  demux_stream #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: one buffered word (or none) and a saturating drop count.
  bit             m_full = 1'b0;
  logic [W-1:0]   m_data = '0;
  int             m_dest = 0;
  int             m_drop = 0;
  bit             acc, dlv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update from the rules: accept when empty or the held word drains.
  always @(posedge clk) begin
    acc = bus.i_valid && (!m_full || bus.y_ready[m_dest]);
    dlv = m_full && bus.y_ready[m_dest];
    if (rst) begin
      m_full = 1'b0;
      m_data = '0;
      m_dest = 0;
      m_drop = 0;
    end else begin
      if (dlv) m_full = 1'b0;
      if (acc) begin
        if (int'(bus.s) < CH) begin
          m_full = 1'b1;
          m_data = bus.i;
          m_dest = int'(bus.s);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    logic [CH-1:0]   e_valid;
    logic [CH*W-1:0] e_y;
    if (chk_en) begin
      e_valid = '0;
      e_y     = '0;
      if (m_full) begin
        e_valid[m_dest]      = 1'b1;
        e_y[m_dest*W +: W]   = m_data;
      end
      chk("model_y_valid", 32'(bus.y_valid), 32'(e_valid));
      chk("model_y", 32'(bus.y), 32'(e_y));
      chk("model_i_ready", 32'(bus.i_ready), 32'(!m_full || bus.y_ready[m_dest]));
      chk("model_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end

  initial begin
    // Reset held two cycles with a valid word offered.
    rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i = 8'hFF;
    bus.s = 2'd1;
    bus.y_ready = 3'b000;
    tick();
    tick();
    chk("rst_y_valid", 32'(bus.y_valid), 32'h0);
    chk("rst_y", 32'(bus.y), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_i_ready", 32'(bus.i_ready), 32'h1);
    chk_en = 1'b1;
    rst = 1'b0;
    bus.i_valid = 1'b0;
    tick();

    // Single routing to channel 2 with a stalled consumer.
    bus.i = 8'hA5;
    bus.s = 2'd2;
    bus.i_valid = 1'b1;
    tick();
    chk("route_y_valid", 32'(bus.y_valid), 32'h4);
    chk("route_y", 32'(bus.y), 32'hA5_0000);
    chk("route_i_ready", 32'(bus.i_ready), 32'h0);
    bus.i_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("hold_y", 32'(bus.y), 32'hA5_0000);
    end
    bus.y_ready = 3'b100;
    #1;
    chk("drain_i_ready", 32'(bus.i_ready), 32'h1);
    tick();
    chk("drain_y_valid", 32'(bus.y_valid), 32'h0);

    // Back-to-back throughput across all channels.
    bus.y_ready = 3'b111;
    bus.i_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      bus.i = 8'(n + 1);
      bus.s = 2'(n);
      #1;
      chk("b2b_i_ready", 32'(bus.i_ready), 32'h1);
      tick();
      chk("b2b_y_valid", 32'(bus.y_valid), 32'(1 << n));
      chk("b2b_y", 32'(bus.y), 32'((n + 1) << (8 * n)));
    end
    bus.i_valid = 1'b0;
    tick();
    chk("b2b_empty", 32'(bus.y_valid), 32'h0);

    // Backpressure: ready only on channels not holding the word.
    bus.y_ready = 3'b000;
    bus.i = 8'h77;
    bus.s = 2'd0;
    bus.i_valid = 1'b1;
    tick();
    bus.y_ready = 3'b110;
    bus.i = 8'h88;
    bus.s = 2'd1;
    #1;
    chk("bp_i_ready", 32'(bus.i_ready), 32'h0);
    tick();
    tick();
    chk("bp_y", 32'(bus.y), 32'h77);
    chk("bp_y_valid", 32'(bus.y_valid), 32'h1);
    bus.i_valid = 1'b0;
    bus.y_ready = 3'b001;
    tick();
    chk("bp_drained", 32'(bus.y_valid), 32'h0);

    // Out-of-range select saturates the drop counter.
    bus.y_ready = 3'b111;
    bus.i = 8'h55;
    bus.s = 2'd3;
    bus.i_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (bus.y_valid != '0) chk("oor_y_valid", 32'(bus.y_valid), 32'h0);
    end
    chk("oor_drop_sat", 32'(drop_cnt), 32'd255);
    bus.i_valid = 1'b0;
    tick();
    chk("oor_drop_hold", 32'(drop_cnt), 32'd255);

    // Reset mid-operation discards the held word.
    bus.y_ready = 3'b000;
    bus.i = 8'h3C;
    bus.s = 2'd1;
    bus.i_valid = 1'b1;
    tick();
    chk("mid_full", 32'(bus.y), 32'h3C00);
    rst = 1'b1;
    bus.y_ready = 3'b010;
    bus.i = 8'h11;
    bus.s = 2'd0;
    tick();
    chk("mid_rst_valid", 32'(bus.y_valid), 32'h0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
    chk("mid_rst_i_ready", 32'(bus.i_ready), 32'h1);
    rst = 1'b0;
    bus.i_valid = 1'b0;
    tick();

    // Randomised traffic, checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i = 8'($urandom);
      bus.s = 2'($urandom_range(0, 3));
      bus.y_ready = 3'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    bus.i_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
